sdram_device_responder: RTL
===========================

// Module: sdram_device_responder
// PURPOSE
//  Device-side end of the SDRAM command interface driven by sdram_controller.
//  Decodes cs/ras/cas/we and the address bus, enforces the init sequence and
//  the tRCD/tRP/tRFC gaps, holds a small single-bank array, and returns read
//  data after the programmed CAS latency. Synthesizable stand-in for an SDRAM
//  chip, used for on-die loopback and controller verification.
// PARAMETERS
//  ADDR_W  13  width of io_sdram_control_address_bus
//  ROW_W   3   row bits, taken from address[ROW_W-1:0] on ACTIVE
//  COL_W   3   column bits, taken from address[COL_W-1:0] on READ/WRITE
//  DATA_W  8   data word width
//  T_RCD   2   cycles from ACTIVE to first legal READ/WRITE
//  T_RP    2   cycles from PRECHARGE to next legal command
//  T_RFC   4   cycles from AUTO REFRESH to next legal command
// PORTS
//  clock                         in   1       single clock, rising edge
//  reset                         in   1       synchronous, active-high
//  io_sdram_control_cs           in   1       chip select, active low
//  io_sdram_control_ras          in   1       row strobe, active low
//  io_sdram_control_cas          in   1       column strobe, active low
//  io_sdram_control_we           in   1       write enable, active low
//  io_sdram_control_address_bus  in   ADDR_W  row/column/mode value
//  io_dq_in                      in   DATA_W  write data, sampled with WRITE
//  io_dq_out                     out  DATA_W  read data
//  io_dq_valid                   out  1       io_dq_out holds read data this cycle
//  io_state_out                  out  3       current FSM state encoding
//  io_error                      out  1       sticky protocol-violation flag
//  io_error_code                 out  2       1=timing, 2=illegal cmd for state, 3=bad mode
// BEHAVIOUR
//  Decoding {cs,ras,cas,we}: 1xxx DESELECT, 0111 NOP, 0011 ACTIVE, 0101 READ,
//   0100 WRITE, 0010 PRECHARGE, 0001 REFRESH, 0000 LOAD_MODE, 0110 BURST_TERM.
//   DESELECT, NOP and BURST_TERM are no-ops in every state.
//  Reset: state=INIT_PRE(0), dq_out=0, dq_valid=0, error=0, code=0, CL=2,
//   gap counter=0, read pipe flushed. The array has no reset; contents persist.
//  States (io_state_out): INIT_PRE 0 -PRECHARGE-> INIT_REF1 1 -REFRESH->
//   INIT_REF2 2 -REFRESH-> INIT_MRS 3 -LOAD_MODE-> IDLE 4 -ACTIVE-> ACTIVE 5
//   -PRECHARGE-> IDLE. In ACTIVE, READ/WRITE leave the state unchanged.
//   In IDLE, REFRESH and LOAD_MODE are legal and stay in IDLE.
//   PRECHARGE in IDLE is legal (no-op plus T_RP gap).
//  Gap counter: ACTIVE loads T_RCD, PRECHARGE loads T_RP, REFRESH loads T_RFC,
//   decremented to 0. A non-no-op command while the counter is nonzero is ignored
//   and raises code 1. ACTIVE loads T_RCD on every transition.
//  Any other command not legal in the current state is ignored and raises code 2.
//  LOAD_MODE: CL=address[6:4], which must be 2 or 3; burst length address[2:0]
//   must be 0 (BL=1). Otherwise the command is ignored, the state does not
//   advance and code 3 is raised.
//  Errors: io_error and io_error_code are sticky until reset. The first error
//   wins; later errors do not overwrite the code.
//  WRITE at edge N: mem[{open_row,col}] <= io_dq_in.
//  READ at edge N: word captured at N. dq_valid=1 and dq_out=word in the cycle
//   after edge N+CL-1 (CL cycles after the command is presented).
//  Back-to-back READs every cycle are legal and produce consecutive valid beats.
//  PRECHARGE after a READ does not cancel that READ's in-flight data.
//  WRITE then READ of the same column on the next cycle returns the new data.
//  When dq_valid=0, dq_out=0.
//  Reset asserted mid-operation flushes the pipe in the same cycle and restarts
//   at INIT_PRE.
// TESTING
//  1. Init PRE,REF,REF,LMR(CL=2) with NOPs covering the gaps -> state steps
//     0,1,2,3,4; io_error=0.
//  2. ACTIVE row 5, 2 NOPs, WRITE col 3 data 0xA5, READ col 3 -> dq_valid=1,
//     dq_out=0xA5 exactly 2 cycles after READ.
//  3. LMR CL=3, then READs of cols 0,1,2 back-to-back -> three consecutive valid
//     beats, the first 3 cycles after the first READ, in column order.
//  4. READ one cycle after ACTIVE (T_RCD=2) -> no data beat; io_error=1, code=1.
//  5. READ while in IDLE -> ignored, code=2. LMR with CL=5 -> code=3 and the state
//     stays INIT_MRS.
//  6. Assert reset 1 cycle after a READ -> dq_valid never rises; state=0; a prior
//     write is still readable after re-init.

Source files
------------

// File: rtl/sdram_device_responder.sv
// rtl/sdram_device_responder.sv - Single-bank SDRAM device stand-in with init sequencing, gap timing and CAS-latency reads
module sdram_device_responder #(
  parameter int ADDR_W = 13,
  parameter int ROW_W  = 3,
  parameter int COL_W  = 3,
  parameter int DATA_W = 8,
  parameter int T_RCD  = 2,
  parameter int T_RP   = 2,
  parameter int T_RFC  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_sdram_control_cs,
  input  logic              io_sdram_control_ras,
  input  logic              io_sdram_control_cas,
  input  logic              io_sdram_control_we,
  input  logic [ADDR_W-1:0] io_sdram_control_address_bus,
  input  logic [DATA_W-1:0] io_dq_in,
  output logic [DATA_W-1:0] io_dq_out,
  output logic              io_dq_valid,
  output logic [2:0]        io_state_out,
  output logic              io_error,
  output logic [1:0]        io_error_code
);

  localparam int GAP_W  = 8;
  localparam int MEM_AW = ROW_W + COL_W;

  typedef enum logic [2:0] {
    S_INIT_PRE  = 3'd0,
    S_INIT_REF1 = 3'd1,
    S_INIT_REF2 = 3'd2,
    S_INIT_MRS  = 3'd3,
    S_IDLE      = 3'd4,
    S_ACTIVE    = 3'd5
  } state_t;

  state_t            state;
  logic [GAP_W-1:0]  gap;
  logic [2:0]        cl;
  logic [ROW_W-1:0]  open_row;
  logic [DATA_W-1:0] mem [2**MEM_AW];
  logic              s1_v, s2_v;
  logic [DATA_W-1:0] s1_d, s2_d;

  logic [2:0]        cmd;
  logic              sel, is_noop, is_act, is_rd, is_wr, is_pre, is_ref, is_lmr, mode_ok;
  logic [MEM_AW-1:0] mem_idx;
  logic              do_act, do_rd, do_wr, do_pre, do_ref, do_lmr;
  logic [1:0]        err_new;
  logic              unused_addr;

  assign cmd     = {io_sdram_control_ras, io_sdram_control_cas, io_sdram_control_we};
  assign sel     = !io_sdram_control_cs;
  assign is_noop = !sel || cmd == 3'b111 || cmd == 3'b110;
  assign is_act  = sel && cmd == 3'b011;
  assign is_rd   = sel && cmd == 3'b101;
  assign is_wr   = sel && cmd == 3'b100;
  assign is_pre  = sel && cmd == 3'b010;
  assign is_ref  = sel && cmd == 3'b001;
  assign is_lmr  = sel && cmd == 3'b000;
  assign mode_ok = (io_sdram_control_address_bus[6:4] == 3'd2 ||
                    io_sdram_control_address_bus[6:4] == 3'd3) &&
                   io_sdram_control_address_bus[2:0] == 3'd0;
  assign mem_idx = {open_row, io_sdram_control_address_bus[COL_W-1:0]};
  assign unused_addr = ^io_sdram_control_address_bus;
  assign io_state_out = state;

  // Timing violations take precedence over legality; mode errors only apply to otherwise-legal LMRs.
  always_comb begin
    do_act  = 1'b0;
    do_rd   = 1'b0;
    do_wr   = 1'b0;
    do_pre  = 1'b0;
    do_ref  = 1'b0;
    do_lmr  = 1'b0;
    err_new = 2'd0;
    if (!is_noop) begin
      if (gap != '0) begin
        err_new = 2'd1;
      end else begin
        case (state)
          S_INIT_PRE: if (is_pre) do_pre = 1'b1; else err_new = 2'd2;
          S_INIT_REF1, S_INIT_REF2: if (is_ref) do_ref = 1'b1; else err_new = 2'd2;
          S_INIT_MRS: if (is_lmr) do_lmr = 1'b1; else err_new = 2'd2;
          S_IDLE: begin
            if (is_act)      do_act  = 1'b1;
            else if (is_ref) do_ref  = 1'b1;
            else if (is_lmr) do_lmr  = 1'b1;
            else if (is_pre) do_pre  = 1'b1;
            else             err_new = 2'd2;
          end
          S_ACTIVE: begin
            if (is_rd)       do_rd   = 1'b1;
            else if (is_wr)  do_wr   = 1'b1;
            else if (is_pre) do_pre  = 1'b1;
            else             err_new = 2'd2;
          end
          default: err_new = 2'd2;
        endcase
        if (do_lmr && !mode_ok) begin
          do_lmr  = 1'b0;
          err_new = 2'd3;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_INIT_PRE;
      gap           <= '0;
      cl            <= 3'd2;
      open_row      <= '0;
      s1_v          <= 1'b0;
      s2_v          <= 1'b0;
      s1_d          <= '0;
      s2_d          <= '0;
      io_dq_out     <= '0;
      io_dq_valid   <= 1'b0;
      io_error      <= 1'b0;
      io_error_code <= 2'd0;
    end else begin
      if (do_pre) begin
        state <= (state == S_INIT_PRE) ? S_INIT_REF1 : S_IDLE;
        gap   <= GAP_W'(T_RP - 1);
      end else if (do_ref) begin
        state <= (state == S_INIT_REF1) ? S_INIT_REF2 :
                 (state == S_INIT_REF2) ? S_INIT_MRS : S_IDLE;
        gap   <= GAP_W'(T_RFC - 1);
      end else if (do_act) begin
        state    <= S_ACTIVE;
        open_row <= io_sdram_control_address_bus[ROW_W-1:0];
        gap      <= GAP_W'(T_RCD - 1);
      end else begin
        if (do_lmr) begin
          cl    <= io_sdram_control_address_bus[6:4];
          state <= S_IDLE;
        end
        if (gap != '0) gap <= gap - GAP_W'(1);
      end
      // Two-stage read pipe; CL selects which stage feeds the output register.
      s1_v <= do_rd;
      s1_d <= mem[mem_idx];
      s2_v <= s1_v;
      s2_d <= s1_d;
      if (cl == 3'd3) begin
        io_dq_valid <= s2_v;
        io_dq_out   <= s2_v ? s2_d : '0;
      end else begin
        io_dq_valid <= s1_v;
        io_dq_out   <= s1_v ? s1_d : '0;
      end
      if (!io_error && err_new != 2'd0) begin
        io_error      <= 1'b1;
        io_error_code <= err_new;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && do_wr) mem[mem_idx] <= io_dq_in;
  end

endmodule
